calc_corr: RTL and testbench
============================

Name: calc_corr

Overview:
- Sequential correlation engine: corr = sum over i of A[i]*r[i], in sign-magnitude Q-format fixed point.
- It is the reader-side counterpart of the residual updater. It consumes the residual vector r and column A, and produces the scalar that the controller uses to form x_hat for the next residual update.
- One shared multiplier is time-multiplexed over the I elements. The block uses a start/ready handshake.

Parameters:
- I, 20, vector length (number of elements of A and r); I >= 1.
- Q, 15, fractional bits.
- N, 32, word width; bit N-1 is the sign, bits N-2:0 are the magnitude.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  N x [0:I-1]  column vector, sign-magnitude Q format.
- r  input  N x [0:I-1]  residual vector, sign-magnitude Q format.
- corr  output  N  result, sign-magnitude; held until the next completion.
- ready  output  1  one-cycle pulse when corr is updated.
- busy  output  1  high in ACC and DONE.
- overflow  output  1  sticky per operation; valid with ready, held with corr.

Behaviour:
- Reset: corr=0, ready=0, busy=0, overflow=0, state=IDLE, acc=0, idx=0. Captured A/r registers are cleared to 0.
- FSM states are IDLE, ACC, DONE.
- IDLE:
  - On start=1 at edge k: A and r are copied into internal registers.
  - acc<=0, idx<=0, the operation's overflow flag is cleared, state->ACC.
  - Inputs may change after edge k without affecting the result.
- ACC:
  - Each edge adds product(A_reg[idx], r_reg[idx]) to acc and increments idx.
  - The edge that adds element I-1 moves state->DONE. Edges k+1..k+I are accumulate edges.
- DONE, at edge k+I+1:
  - acc is converted to corr, ready<=1, busy<=0, state->IDLE.
  - ready is high exactly one cycle. Latency from the start-sampling edge to ready high is I+1 edges.
- start in ACC/DONE is ignored: no queueing, no restart.
- start during the ready cycle (state IDLE) is accepted, giving back-to-back operation. corr stays stable until the next DONE edge.
- Product rules:
  - mag = (|a| * |b|) >> Q, truncated. The full 2(N-1)-bit product is formed first.
  - If mag > 2^(N-1)-1, mag saturates to 2^(N-1)-1 and overflow<=1.
  - sign = sign(a) XOR sign(b). The product is converted to two's complement before adding.
- Accumulator: signed two's complement, width N + clog2(I) + 1, so no intermediate wrap occurs.
- Final conversion:
  - If |acc| > 2^(N-1)-1, the magnitude saturates to 2^(N-1)-1 with the sign of acc, and overflow<=1.
  - A result of zero always has sign=0; negative zero is never output.
  - A negative-zero input (sign=1, magnitude=0) is treated as 0.
- Reset asserted mid-operation aborts immediately to the reset values; no ready is produced.

Optional Feature:
- Macro: CALC_CORR_ROUND_EN.
- Defined: each product magnitude is rounded half-up, i.e. 2^(Q-1) is added to the full product before >> Q. Saturation is checked after rounding.
- Undefined: truncation as specified in Behaviour.
- Latency and the interface are identical in both builds.

Test Plan:
- Timing/basic (Q=15, N=32, I=20): A[i]=0x00008000 (1.0), r[i]=0x00004000 (0.5); start pulse at edge k -> ready single pulse after edge k+21, corr=0x00050000 (10.0), overflow=0, busy high for exactly 21 cycles.
- Sign: A[0]=0x80008000 (-1.0), r[0]=0x00010000 (2.0), all other elements 0 -> corr=0x80010000 (-2.0).
- Cancellation: A[0]=A[1]=0x00008000, r[0]=0x00008000, r[1]=0x80008000, rest 0 -> corr=0x00000000, sign bit 0.
- Overflow: all A[i]=r[i]=0x7FFFFFFF -> corr=0x7FFFFFFF, overflow=1. Next operation with the basic vectors -> overflow=0, corr=0x00050000.
- Handshake:
  - A second start is pulsed during ACC -> ignored, only one ready.
  - start in the ready cycle -> the second ready arrives 21 edges later.
  - rst_n pulsed low at edge k+5 -> outputs go to 0 asynchronously, no ready follows.
- Rounding: A[i]=0x00000001, r[i]=0x00004000 -> corr=0x00000000 without the macro, corr=0x00000014 with CALC_CORR_ROUND_EN defined.

Source files
------------

// File: rtl/calc_corr.sv
// Sequential correlation engine: corr = sum A[i]*r[i] in sign-magnitude Q format,
// one shared multiplier over I elements. Define CALC_CORR_ROUND_EN for half-up product rounding.
module calc_corr #(
    parameter int I = 20,
    parameter int Q = 15,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A [0:I-1],
    input  logic [N-1:0] r [0:I-1],
    output logic [N-1:0] corr,
    output logic         ready,
    output logic         busy,
    output logic         overflow
);

    localparam int MAG_W = N - 1;
    localparam int P_W   = 2 * MAG_W;
    localparam int ACC_W = N + $clog2(I) + 1;
    localparam int IDX_W = (I > 1) ? $clog2(I) : 1;
    localparam logic [MAG_W-1:0] MAG_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                    state, state_nxt;
    logic [N-1:0]              a_reg [0:I-1];
    logic [N-1:0]              r_reg [0:I-1];
    logic signed [ACC_W-1:0]   acc;
    logic [IDX_W-1:0]          idx;
    logic                      op_ovf;

    logic [MAG_W:0]            prod_sat;
    logic [MAG_W-1:0]          prod_mag;
    logic [ACC_W-1:0]          prod_ext;
    logic                      prod_neg;
    logic signed [ACC_W-1:0]   prod_tc;
    logic [N:0]                fin;

    // Full-width magnitude product scaled back to Q format (optionally rounded half-up).
    function automatic logic [P_W-1:0] scale_mag(input logic [MAG_W-1:0] a, input logic [MAG_W-1:0] b);
        logic [P_W:0] p;
        p = (P_W+1)'(a) * (P_W+1)'(b);
`ifdef CALC_CORR_ROUND_EN
        p = p + ((P_W+1)'(1) << (Q - 1));
`endif
        return P_W'(p >> Q);
    endfunction

    // Returns {saturated, magnitude}.
    function automatic logic [MAG_W:0] sat_mag(input logic [P_W-1:0] m);
        if (m > P_W'(MAG_MAX))
            return {1'b1, MAG_MAX};
        return {1'b0, m[MAG_W-1:0]};
    endfunction

    // Returns {saturated, sign, magnitude}; zero never carries a sign.
    function automatic logic [N:0] acc_to_sm(input logic signed [ACC_W-1:0] a);
        logic [ACC_W-1:0] m;
        logic             neg;
        neg = a[ACC_W-1];
        m   = neg ? ACC_W'(-a) : ACC_W'(a);
        if (m > ACC_W'(MAG_MAX))
            return {1'b1, neg, MAG_MAX};
        return {1'b0, neg && (m != '0), m[MAG_W-1:0]};
    endfunction

    always_comb begin
        prod_sat = sat_mag(scale_mag(a_reg[idx][MAG_W-1:0], r_reg[idx][MAG_W-1:0]));
        prod_mag = prod_sat[MAG_W-1:0];
        prod_neg = a_reg[idx][N-1] ^ r_reg[idx][N-1];
        prod_ext = ACC_W'(prod_mag);
        prod_tc  = prod_neg ? -$signed(prod_ext) : $signed(prod_ext);
        fin      = acc_to_sm(acc);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACC;
            ACC:     if (idx == IDX_W'(I - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            idx      <= '0;
            op_ovf   <= 1'b0;
            corr     <= '0;
            ready    <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < I; i++) begin
                a_reg[i] <= '0;
                r_reg[i] <= '0;
            end
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_reg  <= A;
                    r_reg  <= r;
                    acc    <= '0;
                    idx    <= '0;
                    op_ovf <= 1'b0;
                end
                ACC: begin
                    acc    <= acc + prod_tc;
                    idx    <= idx + IDX_W'(1);
                    op_ovf <= op_ovf | prod_sat[MAG_W];
                end
                DONE: begin
                    corr     <= fin[N-1:0];
                    overflow <= op_ovf | fin[N];
                    ready    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_corr.sv
// Bench for calc_corr: directed literal cases plus randomized traffic against an arithmetic model.
module tb_calc_corr;

    localparam int I = 20;
    localparam int Q = 15;
    localparam int N = 32;
    localparam longint unsigned MAXM = 64'h7FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] A [0:I-1];
    logic [31:0] r [0:I-1];
    logic [31:0] corr;
    logic        ready, busy, overflow;

    int n_checks = 0;
    int n_pass   = 0;

    int          cnt = 0;
    logic        m_ready = 1'b0;
    logic        m_ovf = 1'b0;
    logic        pend_ovf = 1'b0;
    logic [31:0] m_corr = '0;
    logic [31:0] pend_corr = '0;

    always #5 clk = ~clk;

    calc_corr #(.I(I), .Q(Q), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .r(r),
        .corr(corr), .ready(ready), .busy(busy), .overflow(overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Straight arithmetic from the product/accumulate/convert rules.
    function automatic void model(input logic [31:0] a [0:I-1], input logic [31:0] b [0:I-1],
                                  output logic [31:0] c, output logic o);
        longint          s;
        longint unsigned p, m;
        bit              neg;
        s = 0;
        o = 1'b0;
        for (int i = 0; i < I; i++) begin
            p = 64'(a[i][30:0]) * 64'(b[i][30:0]);
`ifdef CALC_CORR_ROUND_EN
            p = p + (64'd1 << (Q - 1));
`endif
            p = p >> Q;
            if (p > MAXM) begin p = MAXM; o = 1'b1; end
            if (a[i][31] ^ b[i][31]) s = s - longint'(p);
            else                     s = s + longint'(p);
        end
        neg = (s < 0);
        m = 64'(neg ? -s : s);
        if (m > MAXM) begin m = MAXM; o = 1'b1; end
        c = {neg && (m != 0), m[30:0]};
    endfunction

    // Expected outputs: start accepted only when idle, result appears I+1 edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt = 0; m_ready = 1'b0; m_corr = '0; m_ovf = 1'b0;
        end else begin
            m_ready = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    m_ready = 1'b1; m_corr = pend_corr; m_ovf = pend_ovf;
                end
            end else if (start) begin
                model(A, r, pend_corr, pend_ovf);
                cnt = I + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready", 64'(ready), 64'(m_ready));
            chk("busy", 64'(busy), 64'(cnt > 0));
            chk("corr", 64'(corr), 64'(m_corr));
            chk("overflow", 64'(overflow), 64'(m_ovf));
        end
    end

    task automatic set_all(input logic [31:0] x, input logic [31:0] y);
        for (int i = 0; i < I; i++) begin A[i] = x; r[i] = y; end
    endtask

    task automatic run_op(output int edges, output int bcyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        bcyc = int'(busy);
        while (!ready && edges < 60) begin
            @(negedge clk);
            edges++;
            bcyc += int'(busy);
        end
        if (!ready) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [31:0] rnd_elem();
        int k;
        k = int'($urandom_range(0, 9));
        if (k == 0) return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h0;
        if (k <= 6) return {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h3_FFFF))};
        if (k <= 8) return {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'hFF_FFFF))};
        return $urandom;
    endfunction

    initial begin
        int          e, b, n;
        logic [31:0] mc;
        logic        mo;

        #100000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          e, b, n;
        logic [31:0] mc;
        logic        mo;

        set_all(32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_corr", 64'(corr), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        // Pin the model with hand-computed values.
        set_all(32'h0000_8000, 32'h0000_4000);
        model(A, r, mc, mo);
        chk("model_basic", 64'({mo, mc}), 64'({1'b0, 32'h0005_0000}));
        set_all(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        model(A, r, mc, mo);
        chk("model_ovf", 64'({mo, mc}), 64'({1'b1, 32'h7FFF_FFFF}));
        set_all(32'h0, 32'h0);
        A[0] = 32'h8000_8000; r[0] = 32'h0001_0000;
        model(A, r, mc, mo);
        chk("model_sign", 64'(mc), 64'h8001_0000);

        rst_n = 1'b1;
        @(negedge clk);

        set_all(32'h0000_8000, 32'h0000_4000);
        run_op(e, b);
        chk("basic_corr", 64'(corr), 64'h0005_0000);
        chk("basic_ovf", 64'(overflow), 64'd0);
        chk("basic_latency", 64'(e - 1), 64'(I + 1));
        chk("basic_busy_cycles", 64'(b), 64'(I + 1));
        @(negedge clk);
        chk("basic_ready_pulse", 64'(ready), 64'd0);

        set_all(32'h0, 32'h0);
        A[0] = 32'h8000_8000; r[0] = 32'h0001_0000;
        run_op(e, b);
        chk("sign_corr", 64'(corr), 64'h8001_0000);

        set_all(32'h0, 32'h0);
        A[0] = 32'h0000_8000; A[1] = 32'h0000_8000;
        r[0] = 32'h0000_8000; r[1] = 32'h8000_8000;
        run_op(e, b);
        chk("cancel_corr", 64'(corr), 64'h0);

        set_all(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_op(e, b);
        chk("ovf_corr", 64'(corr), 64'h7FFF_FFFF);
        chk("ovf_flag", 64'(overflow), 64'd1);

        set_all(32'h0000_8000, 32'h0000_4000);
        run_op(e, b);
        chk("after_ovf_flag", 64'(overflow), 64'd0);
        chk("after_ovf_corr", 64'(corr), 64'h0005_0000);

        set_all(32'h0000_0001, 32'h0000_4000);
        run_op(e, b);
`ifdef CALC_CORR_ROUND_EN
        chk("round_corr", 64'(corr), 64'h14);
`else
        chk("round_corr", 64'(corr), 64'h0);
`endif

        // Start during ACC must be ignored; inputs changed after capture must not matter.
        set_all(32'h0000_8000, 32'h0000_4000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        set_all(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) begin
                n++;
                chk("ignored_start_corr", 64'(corr), 64'h0005_0000);
            end
        end
        chk("ignored_start_ready_count", 64'(n), 64'd1);

        // Back-to-back: start in the ready cycle.
        set_all(32'h0000_8000, 32'h0000_4000);
        run_op(e, b);
        set_all(32'h0, 32'h0);
        A[0] = 32'h8000_8000; r[0] = 32'h0001_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = 1;
        while (!ready && e < 60) begin
            @(negedge clk);
            e++;
            if (e == 10) chk("b2b_corr_held", 64'(corr), 64'h0005_0000);
        end
        chk("b2b_latency", 64'(e - 1), 64'(I + 1));
        chk("b2b_corr", 64'(corr), 64'h8001_0000);

        // Asynchronous abort mid-operation.
        set_all(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_op(e, b);
        set_all(32'h0000_8000, 32'h0000_4000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_corr", 64'(corr), 64'd0);
        chk("abort_ovf", 64'(overflow), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'(ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (ready) n++;
        end
        chk("abort_no_ready", 64'(n), 64'd0);

        // Randomized traffic; start toggles freely and inputs churn while busy.
        repeat (3000) begin
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) != 0)
                for (int i = 0; i < I; i++) begin A[i] = rnd_elem(); r[i] = rnd_elem(); end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (30) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
